rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-side front end for the 8x8 register file's single write port.
- Accepts write-back requests from two pipeline producers, the ALU result and the memory load result, through valid/ready handshakes.
- Arbitrates the requests round-robin, buffers them in an in-order queue, and drives We/Waddr/In of the register file at most once per cycle.
- Exports a pending-write scoreboard to the decode/hazard logic.

Parameters:
- DATA_W, 8, width of register data.
- ADDR_W, 3, width of register address.
- DEPTH, 4, queue entries; power of 2, at least 2.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous, active-low reset.
- Alu_valid  in  1  ALU write request valid.
- Alu_addr  in  ADDR_W  ALU destination register.
- Alu_data  in  DATA_W  ALU result.
- Alu_ready  out  1  ALU request accepted this cycle.
- Mem_valid  in  1  load write request valid.
- Mem_addr  in  ADDR_W  load destination register.
- Mem_data  in  DATA_W  load data.
- Mem_ready  out  1  load request accepted this cycle.
- Wb_stall  in  1  register-file write port unavailable; hold the queue.
- We  out  1  register-file write enable, registered.
- Waddr  out  ADDR_W  register-file write address, registered.
- Wdata  out  DATA_W  register-file write data (to RF In), registered.
- Chk_addr_a  in  ADDR_W  hazard-check address A.
- Chk_addr_b  in  ADDR_W  hazard-check address B.
- Pend_a  out  1  write to Chk_addr_a queued or presented, combinational.
- Pend_b  out  1  same as Pend_a for Chk_addr_b.
- Count  out  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- The synchronous reset is fixed as stated in the interface: Rst_n is synchronous and active-low on Clk.
- Reset (Rst_n=0 at an edge):
  - queue emptied, Count=0;
  - We=0, Waddr=0, Wdata=0;
  - round-robin pointer = ALU-preferred;
  - in-flight requests dropped, including reset mid-operation.
- Grant, at most one push per cycle:
  - only one requester valid -> it is granted;
  - both valid -> the source not granted last time is granted;
  - pointer updates only on an actual push.
- Readiness: Alu_ready/Mem_ready = granted & (Count < DEPTH).
  - Both ready signals are low when full, regardless of a same-cycle pop.
  - At most one ready is high per cycle.
- A push happens on an edge where valid & ready; the {addr,data} entry is appended at the tail.
- Pop: on an edge where Count>0 and Wb_stall=0, the head is removed and loaded into the output register: We=1, Waddr/Wdata = entry.
- On an edge with no pop, We<=0. Waddr/Wdata hold their values. We is therefore a one-cycle pulse per entry.
- Latency: request accepted at edge k -> We high in the cycle after edge k+1, assuming an empty queue and no stall. Minimum 2 cycles.
- Simultaneous push and pop: Count unchanged, ordering preserved.
- Pointers wrap modulo DEPTH.
- Ordering: writes to the same register leave in acceptance order; no coalescing.
- Pend_a = (We & Waddr==Chk_addr_a) OR any valid queue entry whose addr == Chk_addr_a. Pend_b is the same for Chk_addr_b.
- Wb_stall high with an empty queue: no effect.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: adds outputs Byp_data_a and Byp_data_b, each DATA_W wide and combinational.
  - Each carries the data of the youngest matching write.
  - Youngest is the tail-most queue entry; the output register counts as oldest.
  - Value is 0 when the matching Pend is low.
- Not defined: ports absent; Pend_a/Pend_b only.

Decomposition:
- Package rf_wb_pkg:
  - DATA_W and ADDR_W defaults;
  - wb_entry_t = {addr, data};
  - source enum SRC_ALU=0, SRC_MEM=1 for the round-robin pointer.
- Sub-module rf_wb_fifo:
  - DEPTH-entry, in-order queue of wb_entry_t;
  - push/pop, Count, per-entry valid and addr exposed for the scoreboard and bypass search.
- The arbiter and output register stay in the top module.

Test Plan:
- Single ALU request {addr=3, data=0x5A}, no stall -> Alu_ready=1 at accept edge; We=1, Waddr=3, Wdata=0x5A exactly 2 cycles later, for one cycle.
- Alu_valid and Mem_valid held high for 4 cycles, with ALU and load writes to different registers -> grants alternate ALU, MEM, ALU, MEM; RF write order matches.
- Wb_stall=1 while pushing 5 requests with DEPTH=4 -> Count reaches 4, 5th request sees ready=0; release stall -> 4 writes in order, then the 5th accepted.
- Write r2=0x11 then r2=0x22 with stall held -> Pend_a=1 for Chk_addr_a=2; Byp_data_a=0x22 when bypass is enabled; RF receives 0x11 then 0x22.
- Rst_n=0 for one edge with 3 entries queued and We=1 -> next cycle Count=0, We=0, Pend_a/Pend_b=0; no further writes.
- Push and pop on the same edge with Count=2 -> Count stays 2, head advances, pointer wrap across DEPTH is exercised.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, queue entry type and round-robin source enum for the write-back front end
package rf_wb_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 3;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order write-back queue; exposes an age-ordered view (index 0 = head) for hazard search.
// RF_WB_BYPASS_EN adds the per-entry data view used by the bypass search.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic                               push,
    input  wb_entry_t                          push_entry,
    input  logic                               pop,
    output wb_entry_t                          head,
    output logic [$clog2(DEPTH):0]             count,
    output logic [DEPTH-1:0]                   ent_valid,
`ifdef RF_WB_BYPASS_EN
    output logic [DEPTH-1:0][WB_DATA_W-1:0]    ent_data,
`endif
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]    ent_addr
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // Entry storage needs no reset; validity comes from count
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] idx;
        assign idx          = rd_ptr + PW'(i);
        assign ent_valid[i] = (PW+1)'(i) < count;
        assign ent_addr[i]  = mem[idx].addr;
`ifdef RF_WB_BYPASS_EN
        assign ent_data[i]  = mem[idx].data;
`endif
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/load write-back arbiter feeding the register-file write port
// through an in-order queue, with a pending-write scoreboard. Optional macro RF_WB_BYPASS_EN
// adds Byp_data_a/Byp_data_b carrying the youngest pending write data.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Alu_valid,
    input  logic [ADDR_W-1:0]         Alu_addr,
    input  logic [DATA_W-1:0]         Alu_data,
    output logic                      Alu_ready,
    input  logic                      Mem_valid,
    input  logic [ADDR_W-1:0]         Mem_addr,
    input  logic [DATA_W-1:0]         Mem_data,
    output logic                      Mem_ready,
    input  logic                      Wb_stall,
    output logic                      We,
    output logic [ADDR_W-1:0]         Waddr,
    output logic [DATA_W-1:0]         Wdata,
    input  logic [ADDR_W-1:0]         Chk_addr_a,
    input  logic [ADDR_W-1:0]         Chk_addr_b,
    output logic                      Pend_a,
    output logic                      Pend_b,
`ifdef RF_WB_BYPASS_EN
    output logic [DATA_W-1:0]         Byp_data_a,
    output logic [DATA_W-1:0]         Byp_data_b,
`endif
    output logic [$clog2(DEPTH):0]    Count
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_src_t                         rr_pref;
    logic                            gnt_mem;
    logic                            not_full;
    logic                            push;
    logic                            pop;
    wb_entry_t                       push_entry;
    wb_entry_t                       head;
    logic [DEPTH-1:0]                ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr;
`ifdef RF_WB_BYPASS_EN
    logic [DEPTH-1:0][DATA_W-1:0]    ent_data;
`endif

    // Grant: a lone requester wins; on contention the preferred source wins; full blocks both
    always_comb begin
        not_full   = Count < CW'(DEPTH);
        gnt_mem    = Mem_valid & (!Alu_valid | (rr_pref == SRC_MEM));
        Alu_ready  = Alu_valid & !gnt_mem & not_full;
        Mem_ready  = gnt_mem & not_full;
        push       = Alu_ready | Mem_ready;
        pop        = (Count != '0) & !Wb_stall;
        push_entry = Mem_ready ? {Mem_addr, Mem_data} : {Alu_addr, Alu_data};
    end

    // Preference flips to the other source only when a push actually happens
    always_ff @(posedge Clk) begin
        if (!Rst_n) rr_pref <= SRC_ALU;
        else if (push) rr_pref <= Mem_ready ? SRC_ALU : SRC_MEM;
    end

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (Count),
        .ent_valid  (ent_valid),
`ifdef RF_WB_BYPASS_EN
        .ent_data   (ent_data),
`endif
        .ent_addr   (ent_addr)
    );

    // Output register: one-cycle We pulse per popped entry; address/data hold otherwise
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            We    <= 1'b0;
            Waddr <= '0;
            Wdata <= '0;
        end else begin
            We <= pop;
            if (pop) {Waddr, Wdata} <= head;
        end
    end

    // Pending scoreboard: presented write plus every valid queued entry
    always_comb begin
        Pend_a = We & (Waddr == Chk_addr_a);
        Pend_b = We & (Waddr == Chk_addr_b);
        for (int j = 0; j < DEPTH; j++) begin
            Pend_a = Pend_a | (ent_valid[j] & (ent_addr[j] == Chk_addr_a));
            Pend_b = Pend_b | (ent_valid[j] & (ent_addr[j] == Chk_addr_b));
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Bypass: scan oldest (output register, then head) to youngest so the tail-most match wins
    always_comb begin
        Byp_data_a = (We & (Waddr == Chk_addr_a)) ? Wdata : '0;
        Byp_data_b = (We & (Waddr == Chk_addr_b)) ? Wdata : '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (ent_valid[j] && ent_addr[j] == Chk_addr_a) Byp_data_a = ent_data[j];
            if (ent_valid[j] && ent_addr[j] == Chk_addr_b) Byp_data_b = ent_data[j];
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Alu_valid = 1'b0;
    logic [2:0] Alu_addr = '0;
    logic [7:0] Alu_data = '0;
    logic       Alu_ready;
    logic       Mem_valid = 1'b0;
    logic [2:0] Mem_addr = '0;
    logic [7:0] Mem_data = '0;
    logic       Mem_ready;
    logic       Wb_stall = 1'b0;
    logic       We;
    logic [2:0] Waddr;
    logic [7:0] Wdata;
    logic [2:0] Chk_addr_a = '0;
    logic [2:0] Chk_addr_b = '0;
    logic       Pend_a;
    logic       Pend_b;
    logic [2:0] Count;
`ifdef RF_WB_BYPASS_EN
    logic [7:0] Byp_data_a;
    logic [7:0] Byp_data_b;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;

    rf_wb_arbiter dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Alu_valid  (Alu_valid),
        .Alu_addr   (Alu_addr),
        .Alu_data   (Alu_data),
        .Alu_ready  (Alu_ready),
        .Mem_valid  (Mem_valid),
        .Mem_addr   (Mem_addr),
        .Mem_data   (Mem_data),
        .Mem_ready  (Mem_ready),
        .Wb_stall   (Wb_stall),
        .We         (We),
        .Waddr      (Waddr),
        .Wdata      (Wdata),
        .Chk_addr_a (Chk_addr_a),
        .Chk_addr_b (Chk_addr_b),
        .Pend_a     (Pend_a),
        .Pend_b     (Pend_b),
`ifdef RF_WB_BYPASS_EN
        .Byp_data_a (Byp_data_a),
        .Byp_data_b (Byp_data_b),
`endif
        .Count      (Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", n, act, exp);
        end
    endtask

    // Check readiness before the edge, record what the bench expects to be accepted, advance to edge+1
    task automatic tick(input logic ear, input logic emr);
        @(negedge Clk);
        chk("alu_ready", {31'd0, Alu_ready}, {31'd0, ear});
        chk("mem_ready", {31'd0, Mem_ready}, {31'd0, emr});
        if (ear) exp_q.push_back({Alu_addr, Alu_data});
        if (emr) exp_q.push_back({Mem_addr, Mem_data});
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest expected write
    always @(negedge Clk) begin
        if (Rst_n && We) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rf_write: got addr %0d data %0h, want no write", Waddr, Wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (Waddr !== mon_e[10:8] || Wdata !== mon_e[7:0]) begin
                    fails++;
                    $display("FAIL rf_write: got addr %0d data %0h, want addr %0d data %0h",
                             Waddr, Wdata, mon_e[10:8], mon_e[7:0]);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", Count, 0);
        chk("rst_we", We, 0);
        chk("rst_waddr", Waddr, 0);
        chk("rst_wdata", Wdata, 0);
        chk("rst_pend_a", Pend_a, 0);
        chk("rst_pend_b", Pend_b, 0);
        Rst_n = 1'b1;

        // single ALU write, 2-cycle latency, one-cycle pulse
        Alu_valid = 1; Alu_addr = 3; Alu_data = 8'h5A;
        tick(1, 0);
        Alu_valid = 0;
        chk("lat_we_k", We, 0);
        chk("lat_count_k", Count, 1);
        tick(0, 0);
        chk("lat_we_k1", We, 1);
        chk("lat_waddr", Waddr, 3);
        chk("lat_wdata", Wdata, 8'h5A);
        chk("lat_count_k1", Count, 0);
        tick(0, 0);
        chk("lat_we_k2", We, 0);

        // load alone makes ALU preferred, then both held high alternate ALU, MEM, ALU, MEM
        Mem_valid = 1; Mem_addr = 7; Mem_data = 8'h77;
        tick(0, 1);
        Mem_addr = 5; Mem_data = 8'hB5; Alu_valid = 1; Alu_addr = 1; Alu_data = 8'hA1;
        tick(1, 0);
        Alu_addr = 4; Alu_data = 8'hA4;
        tick(0, 1);
        Mem_addr = 6; Mem_data = 8'hB6;
        tick(1, 0);
        Alu_valid = 0;
        tick(0, 1);
        Mem_valid = 0;
        repeat (3) tick(0, 0);
        chk("rr_drain_count", Count, 0);

        // stall fills the queue; fifth request blocked even on the releasing pop
        Wb_stall = 1; Alu_valid = 1;
        for (int i = 0; i < 4; i++) begin
            Alu_addr = 3'(i); Alu_data = 8'h30 + 8'(i);
            tick(1, 0);
            chk("stall_count", Count, i + 1);
        end
        Alu_addr = 4; Alu_data = 8'h34;
        tick(0, 0);
        chk("full_count", Count, 4);
        chk("full_we", We, 0);
        Wb_stall = 0;
        tick(0, 0);
        chk("release_count", Count, 3);
        chk("release_we", We, 1);
        tick(1, 0);
        chk("pushpop_count", Count, 3);
        Alu_valid = 0;
        repeat (4) tick(0, 0);
        chk("full_drain_count", Count, 0);
        chk("full_drain_we", We, 0);

        // same-register writes, pending/bypass, then push and pop together at Count=2
        Wb_stall = 1; Chk_addr_a = 2; Chk_addr_b = 5;
        Alu_valid = 1; Alu_addr = 2; Alu_data = 8'h11;
        tick(1, 0);
        Alu_valid = 0; Mem_valid = 1; Mem_addr = 2; Mem_data = 8'h22;
        tick(0, 1);
        Mem_valid = 0;
        chk("raw_count", Count, 2);
        chk("raw_pend_a", Pend_a, 1);
        chk("raw_pend_b", Pend_b, 0);
`ifdef RF_WB_BYPASS_EN
        chk("raw_byp_a", Byp_data_a, 8'h22);
        chk("raw_byp_b", Byp_data_b, 0);
`endif
        Wb_stall = 0; Alu_valid = 1; Alu_addr = 5; Alu_data = 8'h55;
        tick(1, 0);
        Alu_valid = 0;
        chk("pp_count", Count, 2);
        chk("pp_wdata", Wdata, 8'h11);
        chk("pp_pend_a", Pend_a, 1);
        chk("pp_pend_b", Pend_b, 1);
`ifdef RF_WB_BYPASS_EN
        chk("pp_byp_a", Byp_data_a, 8'h22);
        chk("pp_byp_b", Byp_data_b, 8'h55);
`endif
        tick(0, 0);
        chk("out_wdata", Wdata, 8'h22);
        chk("out_pend_a", Pend_a, 1);
        chk("out_count", Count, 1);
`ifdef RF_WB_BYPASS_EN
        chk("out_byp_a", Byp_data_a, 8'h22);
`endif
        tick(0, 0);
        chk("last_pend_a", Pend_a, 0);
        chk("last_pend_b", Pend_b, 1);
`ifdef RF_WB_BYPASS_EN
        chk("last_byp_a", Byp_data_a, 0);
        chk("last_byp_b", Byp_data_b, 8'h55);
`endif
        tick(0, 0);
        chk("idle_count", Count, 0);
        chk("idle_pend_b", Pend_b, 0);

        // reset mid-operation with 3 queued and a write presented
        Wb_stall = 1; Alu_valid = 1; Chk_addr_a = 1; Chk_addr_b = 2;
        for (int i = 0; i < 4; i++) begin
            Alu_addr = 3'(i); Alu_data = 8'h40 + 8'(i);
            tick(1, 0);
        end
        Alu_valid = 0; Wb_stall = 0;
        tick(0, 0);
        chk("prerst_count", Count, 3);
        chk("prerst_we", We, 1);
        Rst_n = 0;
        exp_q.delete();
        tick(0, 0);
        Rst_n = 1;
        chk("midrst_count", Count, 0);
        chk("midrst_we", We, 0);
        chk("midrst_waddr", Waddr, 0);
        chk("midrst_wdata", Wdata, 0);
        chk("midrst_pend_a", Pend_a, 0);
        chk("midrst_pend_b", Pend_b, 0);
        repeat (3) tick(0, 0);
        chk("postrst_count", Count, 0);

        // reset restores ALU preference
        Alu_valid = 1; Alu_addr = 1; Alu_data = 8'h61;
        Mem_valid = 1; Mem_addr = 2; Mem_data = 8'h62;
        tick(1, 0);
        Alu_valid = 0;
        tick(0, 1);
        Mem_valid = 0;
        repeat (3) tick(0, 0);
        chk("final_count", Count, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
